key_line_controller: RTL and testbench
======================================

KEY_LINE_CONTROLLER -- requirements
Module: key_line_controller

Interface
REQ-001 SHALL have parameter KEY_LINE, default 10'd20: line index within a field (counted from vsync) that carries the key.
REQ-002 SHALL have parameter LINE_SAMPLES, default 11'd1440: interleaved luma/chroma samples per active line.
REQ-003 SHALL have parameter CONFIRM_COUNT, default 2'd2: consecutive identical detections required before a key is presented.
REQ-004 SHALL have parameter TIMEOUT_FIELDS, default 4'd8: consecutive fields without a valid detection before lock is dropped.
REQ-005 SHALL have port clock  input  1  sample clock from the decoder; all logic on its rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port vsync_in  input  1  decoder vertical sync, active-high, synchronous to clock.
REQ-008 SHALL have port hsync_in  input  1  decoder horizontal sync, active-high, synchronous to clock.
REQ-009 SHALL have port avid_in  input  1  decoder active-video flag, synchronous to clock.
REQ-010 SHALL have port det_reset_n  output  1  active-low hold of the downstream sequence detector.
REQ-011 SHALL have port det_sequence  input  32  key bits from the detector.
REQ-012 SHALL have port det_ready  input  1  detector id-match flag.
REQ-013 SHALL have port key_out  output  32  confirmed key.
REQ-014 SHALL have port key_valid  output  1  key_out holds an unacknowledged key.
REQ-015 SHALL have port key_ack  input  1  consumer accepts key_out.
REQ-016 SHALL have port lock  output  1  a key has been confirmed and no timeout has since occurred.
REQ-017 SHALL have port key_drop  output  1  one-cycle pulse: confirmed key discarded because key_valid was still high.

Function
REQ-018 SHALL detect rising edges of vsync_in, hsync_in and avid_in using one previous-value register each.
REQ-019 SHALL clear the 10-bit line counter on a vsync_in rising edge and increment it on each hsync_in rising edge, saturating at 10'h3FF.
REQ-020 SHALL implement states IDLE, COUNT, ARM, CAPTURE, EVAL.
REQ-021 SHALL go IDLE->COUNT on a vsync_in rising edge.
REQ-022 SHALL go COUNT->ARM on the cycle the line counter equals KEY_LINE.
REQ-023 SHALL go ARM->CAPTURE on an avid_in rising edge, clear the 11-bit sample counter, and drive det_reset_n high from the next cycle.
REQ-024 SHALL stay in CAPTURE, incrementing the sample counter each cycle, until it equals LINE_SAMPLES+1, then go to EVAL.
REQ-025 SHALL drive det_reset_n low in every state except CAPTURE, including the EVAL cycle.
REQ-026 SHALL sample det_ready and det_sequence in EVAL and go EVAL->IDLE after exactly one cycle.
REQ-027 SHALL force any non-IDLE state to IDLE on a vsync_in rising edge, then start COUNT on that same edge, discarding any partial capture.
REQ-028 SHALL, in EVAL with det_ready=1: increment the match counter (saturating at CONFIRM_COUNT) if det_sequence equals the stored candidate; otherwise store det_sequence as the new candidate and set the match counter to 1.
REQ-029 SHALL, in EVAL with det_ready=0: clear the match counter and increment the miss counter, saturating at TIMEOUT_FIELDS.
REQ-030 SHALL clear the miss counter on any EVAL with det_ready=1.
REQ-031 SHALL count a field with no EVAL as a miss, detected by a vsync_in rising edge while not in IDLE.
REQ-032 SHALL present the candidate when the match counter first reaches CONFIRM_COUNT: if key_valid=0, load key_out and set key_valid and lock the next cycle.
REQ-033 SHALL NOT present the candidate again on subsequent saturated matches.
REQ-034 SHALL, if key_valid=1 when a candidate is to be presented, leave key_out unchanged and pulse key_drop for one cycle.
REQ-035 SHALL hold key_out stable while key_valid=1.
REQ-036 SHALL clear key_valid the cycle after key_ack is sampled high while key_valid=1.
REQ-037 SHALL ignore key_ack while key_valid=0.
REQ-038 SHALL clear lock when the miss counter reaches TIMEOUT_FIELDS; key_valid and key_out are unaffected.

Reset
REQ-039 SHALL, on reset_n low, asynchronously set: state=IDLE, det_reset_n=0, key_out=0, key_valid=0, lock=0, key_drop=0, candidate=0, all counters=0, edge registers=0.
REQ-040 SHALL require a vsync_in rising edge after reset release before capturing.

Verification
REQ-041 Two fields, line 20 carrying key 32'hDEADBEEF with det_ready=1 at EVAL -> key_valid=1, key_out=32'hDEADBEEF and lock=1 after the second EVAL; det_reset_n high for exactly 1442 cycles per field.
REQ-042 Field 1 key 32'h11111111, field 2 key 32'h22222222, field 3 key 32'h22222222 -> key_valid rises only after field 3 with key_out=32'h22222222.
REQ-043 Key confirmed with key_ack held low, then a different key confirmed twice -> key_drop pulses once; key_out keeps the first key; key_ack=1 -> key_valid=0 the next cycle.
REQ-044 After lock, 8 fields with det_ready=0 -> lock=0 at the 8th EVAL; key_out unchanged.
REQ-045 vsync_in rising edge mid-CAPTURE (sample 700) -> det_reset_n=0 next cycle, no EVAL, miss counter +1, COUNT restarted.
REQ-046 reset_n low mid-CAPTURE with key_valid=1 -> all outputs at reset values immediately; no capture until the next vsync_in edge.

Source files
------------

// File: rtl/key_line_controller.sv
// rtl/key_line_controller.sv - captures a per-field key line and confirms the detected key
module key_line_controller #(
    parameter logic [9:0]  KEY_LINE       = 10'd20,
    parameter logic [10:0] LINE_SAMPLES   = 11'd1440,
    parameter logic [1:0]  CONFIRM_COUNT  = 2'd2,
    parameter logic [3:0]  TIMEOUT_FIELDS = 4'd8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        avid_in,
    output logic        det_reset_n,
    input  logic [31:0] det_sequence,
    input  logic        det_ready,
    output logic [31:0] key_out,
    output logic        key_valid,
    input  logic        key_ack,
    output logic        lock,
    output logic        key_drop
);

    typedef enum logic [2:0] {IDLE, COUNT, ARM, CAPTURE, EVAL} state_t;

    // The detector needs LINE_SAMPLES samples plus pipeline slack before EVAL.
    localparam logic [10:0] LAST_SAMPLE = LINE_SAMPLES + 11'd1;

    state_t      state;
    state_t      state_next;
    logic        vsync_d;
    logic        hsync_d;
    logic        avid_d;
    logic        vsync_rise;
    logic        hsync_rise;
    logic        avid_rise;
    logic [9:0]  line_cnt;
    logic [10:0] sample_cnt;
    logic [1:0]  match_cnt;
    logic [1:0]  match_next;
    logic [3:0]  miss_cnt;
    logic [31:0] candidate;
    logic        seq_match;
    logic        eval_hit;
    logic        eval_miss;
    logic        field_miss;
    logic        miss_inc;
    logic        timeout;
    logic        present;

    assign vsync_rise = vsync_in & ~vsync_d;
    assign hsync_rise = hsync_in & ~hsync_d;
    assign avid_rise  = avid_in & ~avid_d;

    assign det_reset_n = (state == CAPTURE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (vsync_rise) state_next = COUNT;
            COUNT:   if (line_cnt == KEY_LINE) state_next = ARM;
            ARM:     if (avid_rise) state_next = CAPTURE;
            CAPTURE: if (sample_cnt == LAST_SAMPLE) state_next = EVAL;
            EVAL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A new field always restarts line counting, abandoning any capture.
        if (vsync_rise) state_next = COUNT;
    end

    always_comb begin
        seq_match  = (det_sequence == candidate);
        eval_hit   = (state == EVAL) && det_ready;
        eval_miss  = (state == EVAL) && !det_ready;
        field_miss = vsync_rise && (state != IDLE) && (state != EVAL);
        miss_inc   = eval_miss || field_miss;
        timeout    = miss_inc && ((miss_cnt == TIMEOUT_FIELDS) || (miss_cnt + 4'd1 == TIMEOUT_FIELDS));
        match_next = 2'd1;
        if (seq_match) begin
            match_next = (match_cnt == CONFIRM_COUNT) ? match_cnt : match_cnt + 2'd1;
        end
        // Present only on the transition into confirmation, not while saturated.
        present = eval_hit && (match_next == CONFIRM_COUNT) &&
                  !(seq_match && (match_cnt == CONFIRM_COUNT));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vsync_d    <= 1'b0;
            hsync_d    <= 1'b0;
            avid_d     <= 1'b0;
            line_cnt   <= 10'd0;
            sample_cnt <= 11'd0;
            match_cnt  <= 2'd0;
            miss_cnt   <= 4'd0;
            candidate  <= 32'd0;
            key_out    <= 32'd0;
            key_valid  <= 1'b0;
            lock       <= 1'b0;
            key_drop   <= 1'b0;
        end else begin
            vsync_d  <= vsync_in;
            hsync_d  <= hsync_in;
            avid_d   <= avid_in;
            key_drop <= 1'b0;

            if (vsync_rise) begin
                line_cnt <= 10'd0;
            end else if (hsync_rise && (line_cnt != 10'h3FF)) begin
                line_cnt <= line_cnt + 10'd1;
            end

            if ((state == ARM) && avid_rise) begin
                sample_cnt <= 11'd0;
            end else if (state == CAPTURE) begin
                sample_cnt <= sample_cnt + 11'd1;
            end

            if (eval_hit) begin
                match_cnt <= match_next;
                miss_cnt  <= 4'd0;
                if (!seq_match) candidate <= det_sequence;
            end else if (eval_miss) begin
                match_cnt <= 2'd0;
            end

            if (miss_inc && (miss_cnt != TIMEOUT_FIELDS)) begin
                miss_cnt <= miss_cnt + 4'd1;
            end

            if (key_valid && key_ack) begin
                key_valid <= 1'b0;
            end

            if (present) begin
                lock <= 1'b1;
                if (key_valid) begin
                    key_drop <= 1'b1;
                end else begin
                    key_out   <= det_sequence;
                    key_valid <= 1'b1;
                end
            end else if (timeout) begin
                lock <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_line_controller.sv
// tb/tb_key_line_controller.sv - scoreboard bench for key_line_controller
module tb_key_line_controller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        vsync_in;
    logic        hsync_in;
    logic        avid_in;
    logic        det_reset_n;
    logic [31:0] det_sequence;
    logic        det_ready;
    logic [31:0] key_out;
    logic        key_valid;
    logic        key_ack;
    logic        lock;
    logic        key_drop;

    typedef struct packed {
        logic        kv;
        logic [31:0] key;
        logic        lk;
        logic [7:0]  drops;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   det_hi_cnt = 0;
    int   drop_cnt = 0;

    key_line_controller dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .vsync_in     (vsync_in),
        .hsync_in     (hsync_in),
        .avid_in      (avid_in),
        .det_reset_n  (det_reset_n),
        .det_sequence (det_sequence),
        .det_ready    (det_ready),
        .key_out      (key_out),
        .key_valid    (key_valid),
        .key_ack      (key_ack),
        .lock         (lock),
        .key_drop     (key_drop)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (det_reset_n) det_hi_cnt++;
        if (key_drop) drop_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_vsync();
        vsync_in = 1'b1;
        tick(); tick();
        vsync_in = 1'b0;
        tick();
    endtask

    task automatic do_lines();
        for (int l = 0; l < 20; l++) begin
            hsync_in = 1'b1;
            tick();
            hsync_in = 1'b0;
            tick(); tick(); tick();
        end
    endtask

    task automatic start_avid();
        avid_in = 1'b0;
        tick();
        det_hi_cnt = 0;
        avid_in = 1'b1;
        tick();
    endtask

    task automatic wait_eval(input string tag);
        int n = 0;
        while (!(det_hi_cnt > 0 && !det_reset_n) && n < 3000) begin
            tick();
            n++;
        end
        avid_in = 1'b0;
        check_val({tag, ".det_hi"}, det_hi_cnt, 32'd1442);
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        tick(); tick();
        e = sb.pop_front();
        check_val({tag, ".key_valid"}, {31'd0, key_valid}, {31'd0, e.kv});
        check_val({tag, ".key_out"}, key_out, e.key);
        check_val({tag, ".lock"}, {31'd0, lock}, {31'd0, e.lk});
        check_val({tag, ".drops"}, drop_cnt, {24'd0, e.drops});
    endtask

    task automatic run_field(input string tag, input logic rdy, input logic [31:0] seq,
                             input logic ekv, input logic [31:0] ekey, input logic elk,
                             input logic [7:0] edrops);
        sb.push_back('{kv: ekv, key: ekey, lk: elk, drops: edrops});
        det_ready = rdy;
        det_sequence = seq;
        do_vsync();
        do_lines();
        start_avid();
        wait_eval(tag);
        check_outputs(tag);
    endtask

    task automatic do_ack(input string tag);
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        check_val({tag, ".ack_kv"}, {31'd0, key_valid}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        vsync_in = 1'b0;
        hsync_in = 1'b0;
        avid_in = 1'b0;
        det_sequence = 32'd0;
        det_ready = 1'b0;
        key_ack = 1'b0;
        tick(); tick(); tick();
        check_val("rst.det_reset_n", {31'd0, det_reset_n}, 32'd0);
        check_val("rst.key_valid", {31'd0, key_valid}, 32'd0);
        check_val("rst.key_out", key_out, 32'd0);
        check_val("rst.lock", {31'd0, lock}, 32'd0);
        check_val("rst.key_drop", {31'd0, key_drop}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic two-field confirmation.
        run_field("a1", 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 8'd0);
        run_field("a2", 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 8'd0);
        do_ack("a");

        // Candidate change restarts the match count.
        do_reset();
        run_field("b1", 1'b1, 32'h11111111, 1'b0, 32'h0, 1'b0, 8'd0);
        run_field("b2", 1'b1, 32'h22222222, 1'b0, 32'h0, 1'b0, 8'd0);
        run_field("b3", 1'b1, 32'h22222222, 1'b1, 32'h22222222, 1'b1, 8'd0);

        // New key confirmed while the old one is unacknowledged.
        run_field("c1", 1'b1, 32'h33333333, 1'b1, 32'h22222222, 1'b1, 8'd0);
        run_field("c2", 1'b1, 32'h33333333, 1'b1, 32'h22222222, 1'b1, 8'd1);
        run_field("c3", 1'b1, 32'h33333333, 1'b1, 32'h22222222, 1'b1, 8'd1);
        do_ack("c");

        // Lock timeout after eight missed fields.
        for (int i = 0; i < 8; i++) begin
            run_field($sformatf("d%0d", i + 1), 1'b0, 32'h0, 1'b0, 32'h22222222,
                      (i < 7) ? 1'b1 : 1'b0, 8'd1);
        end

        // Relock, seven misses, then an aborted capture is the eighth miss.
        run_field("e1", 1'b1, 32'h44444444, 1'b0, 32'h22222222, 1'b0, 8'd1);
        run_field("e2", 1'b1, 32'h44444444, 1'b1, 32'h44444444, 1'b1, 8'd1);
        do_ack("e");
        for (int i = 0; i < 7; i++) begin
            run_field($sformatf("em%0d", i + 1), 1'b0, 32'h0, 1'b0, 32'h44444444, 1'b1, 8'd1);
        end
        det_ready = 1'b1;
        det_sequence = 32'h55555555;
        do_vsync();
        do_lines();
        start_avid();
        n = 0;
        while (det_hi_cnt < 700 && n < 2000) begin
            tick();
            n++;
        end
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        avid_in = 1'b0;
        check_val("abort.det_reset_n", {31'd0, det_reset_n}, 32'd0);
        check_val("abort.lock", {31'd0, lock}, 32'd0);
        tick();
        do_lines();
        sb.push_back('{kv: 1'b0, key: 32'h44444444, lk: 1'b0, drops: 8'd1});
        start_avid();
        wait_eval("abort_resume");
        check_outputs("abort_resume");

        // Asynchronous reset in the middle of a capture.
        run_field("f1", 1'b1, 32'h55555555, 1'b1, 32'h55555555, 1'b1, 8'd1);
        do_vsync();
        do_lines();
        start_avid();
        n = 0;
        while (det_hi_cnt < 300 && n < 2000) begin
            tick();
            n++;
        end
        #2 reset_n = 1'b0;
        #1;
        check_val("mid_rst.det_reset_n", {31'd0, det_reset_n}, 32'd0);
        check_val("mid_rst.key_valid", {31'd0, key_valid}, 32'd0);
        check_val("mid_rst.key_out", key_out, 32'd0);
        check_val("mid_rst.lock", {31'd0, lock}, 32'd0);
        check_val("mid_rst.key_drop", {31'd0, key_drop}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        do_lines();
        start_avid();
        for (int i = 0; i < 1700; i++) tick();
        avid_in = 1'b0;
        check_val("no_vsync.det_hi", det_hi_cnt, 32'd0);
        run_field("f2", 1'b1, 32'h66666666, 1'b0, 32'h0, 1'b0, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
